vending_core_param: RTL and testbench
=====================================

Name: vending_core_param

Overview:
Parametrised next-generation vending controller. It supports N items, a configurable credit width, a run-time price table, per-item stock counters with sold-out lockout, and a cancel/refund path. It sits between the debounced front-panel/coin inputs and the display/actuator drivers. It owns credit accumulation internally, so no separate accumulator instance is needed.

Parameters:
NUM_ITEMS, 4, number of selectable items (>=2)
CREDIT_W, 8, width of credit, price and change values
STOCK_W, 4, width of each per-item stock counter
INIT_STOCK, 5, value loaded into every stock counter on reset/restock (must fit STOCK_W)
DISPENSE_CYCLES, 125_000_000, cycles that dispense/refund is held (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
coin_5  in  1  single-cycle pulse, +5 credit
coin_10  in  1  single-cycle pulse, +10 credit
coin_25  in  1  single-cycle pulse, +25 credit
next_item  in  1  single-cycle pulse, advance selection
select  in  1  single-cycle pulse, request purchase
cancel  in  1  single-cycle pulse, request refund
restock  in  1  single-cycle pulse, reload all stock counters
price_table  in  NUM_ITEMS*CREDIT_W  item i price at bits [i*CREDIT_W +: CREDIT_W]
selected_item  out  $clog2(NUM_ITEMS)  current selection
total  out  CREDIT_W  current credit
change  out  CREDIT_W  change/refund amount
dispense  out  1  high for the whole DISPENSING state
refund  out  1  high for the whole REFUNDING state
coin_return  out  1  one-cycle pulse when a coin is rejected
sold_out  out  1  combinational: stock of selected_item == 0
stock_level  out  STOCK_W  stock of selected_item
state  out  2  IDLE=00, COLLECTING=01, DISPENSING=10, REFUNDING=11

Behaviour:
- Reset (reset==0, async): state=IDLE, selected_item=0, total=0, change=0, timer=0, all stock=INIT_STOCK, dispense=refund=coin_return=0.
- Coin value = sum of all coin pulses asserted in the same cycle (5+10+25 in one cycle = 40).
- Coins are accepted in IDLE/COLLECTING only. Credit is added next cycle and saturates at 2^CREDIT_W-1; overflow is discarded silently.
- Coins arriving in DISPENSING/REFUNDING are not credited. coin_return pulses on the following cycle.
- IDLE -> COLLECTING on any accepted coin.
- next_item: selected_item increments and wraps NUM_ITEMS-1 -> 0. Accepted in IDLE/COLLECTING only; ignored otherwise.
- COLLECTING, cancel -> REFUNDING. Next cycle: change=total, total=0, timer=DISPENSE_CYCLES.
- COLLECTING, select with total >= price[sel] and stock[sel] != 0 -> DISPENSING. Next cycle: change=total-price[sel], total=0, stock[sel] decremented, timer=DISPENSE_CYCLES.
- select with insufficient credit or sold-out item: no state change; credit is retained.
- select/cancel in IDLE: no effect.
- cancel and select in the same cycle: cancel wins.
- Coin and select in the same cycle: the coin is credited, and select is evaluated against the pre-coin total. If the purchase succeeds, the coin is added to change (change = total + coin - price). A coin arriving with cancel is added to the refund in the same way.
- DISPENSING/REFUNDING: timer decrements every cycle. dispense/refund is high for exactly DISPENSE_CYCLES cycles, then -> IDLE. change returns to 0 on the IDLE entry cycle.
- Output timing: dispense/refund and change are registered and valid from the first cycle state shows 10/11.
- restock: accepted in any state; all counters = INIT_STOCK. If restock coincides with a decrement, restock wins.
- price_table is sampled at select; changes during DISPENSING do not alter change.
- Reset asserted mid-dispense aborts immediately to reset values. Credit is lost.

Test Plan:
- DISPENSE_CYCLES=4, prices {25,50,100,200}: coin_25, then select on item 0 -> state 01 then 10; dispense high 4 cycles; change=0; stock[0]=4; back to IDLE.
- coin_25 x3 with item 1 selected, select -> change=25 during dispense; total=0 afterwards.
- coin_10, next_item x5 -> selected_item=1 (wrap); select on item 1 (price 50) -> stays COLLECTING, total=10.
- coin_25 x2, cancel -> REFUNDING for 4 cycles with refund=1 and change=50; then IDLE with total=0.
- INIT_STOCK=1: buy item 0 once; insert 25 and select again -> sold_out=1, no dispense, total=25. Then restock -> stock_level=1, and select dispenses.
- CREDIT_W=8: 11 x coin_25 -> total saturates at 255. coin_5 during DISPENSING -> coin_return pulse; total unchanged. Reset low mid-dispense -> all outputs 0, state 00.

Source files
------------

// File: rtl/vending_core_param.sv
// vending_core_param -- parameterised vending controller core.
//
// Accumulates coin credit (saturating), tracks a wrapping item selection,
// checks purchases against a run-time price table and per-item stock, and
// holds dispense/refund for DISPENSE_CYCLES cycles before returning to IDLE.
//
// Ports:
//   clk            rising-edge system clock
//   reset          asynchronous active-low reset
//   coin_5/10/25   single-cycle coin pulses (values add when coincident)
//   next_item      advance selection (wraps)
//   select/cancel  purchase / refund requests (cancel wins)
//   restock        reload every stock counter to INIT_STOCK
//   price_table    packed prices, item i at [i*CREDIT_W +: CREDIT_W]
//   selected_item  current selection
//   total/change   current credit / change or refund amount
//   dispense/refund high throughout DISPENSING / REFUNDING
//   coin_return    one-cycle pulse for a coin rejected while busy
//   sold_out       stock of the selected item is zero (combinational)
//   stock_level    stock of the selected item
//   state          IDLE=00 COLLECTING=01 DISPENSING=10 REFUNDING=11

// Per-item stock counter; restock has priority over a decrement.
module vending_stock_ctr #(
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_restock,
  input  logic               i_dec,
  output logic [STOCK_W-1:0] o_stock
);
  logic [STOCK_W-1:0] r_stock;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_stock <= STOCK_W'(INIT_STOCK);
    else if (i_restock) r_stock <= STOCK_W'(INIT_STOCK);
    else if (i_dec)     r_stock <= r_stock - 1'b1;
  end

  assign o_stock = r_stock;
endmodule

module vending_core_param #(
  parameter int NUM_ITEMS       = 4,
  parameter int CREDIT_W        = 8,
  parameter int STOCK_W         = 4,
  parameter int INIT_STOCK      = 5,
  parameter int DISPENSE_CYCLES = 125_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          coin_5,
  input  logic                          coin_10,
  input  logic                          coin_25,
  input  logic                          next_item,
  input  logic                          select,
  input  logic                          cancel,
  input  logic                          restock,
  input  logic [NUM_ITEMS*CREDIT_W-1:0] price_table,
  output logic [$clog2(NUM_ITEMS)-1:0]  selected_item,
  output logic [CREDIT_W-1:0]           total,
  output logic [CREDIT_W-1:0]           change,
  output logic                          dispense,
  output logic                          refund,
  output logic                          coin_return,
  output logic                          sold_out,
  output logic [STOCK_W-1:0]            stock_level,
  output logic [1:0]                    state
);
  localparam int SEL_W = $clog2(NUM_ITEMS);
  localparam int TMR_W = $clog2(DISPENSE_CYCLES + 1);
  // Headroom for credit + a 40-unit coin burst before saturation.
  localparam int SUM_W = CREDIT_W + 7;
  localparam logic [CREDIT_W-1:0] CMAX = {CREDIT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_COLL = 2'b01,
    S_DISP = 2'b10,
    S_REF  = 2'b11
  } state_t;

  state_t              r_state, w_nstate;
  logic [SEL_W-1:0]    r_sel, w_nsel;
  logic [CREDIT_W-1:0] r_total, w_ntotal;
  logic [CREDIT_W-1:0] r_change, w_nchange;
  logic [TMR_W-1:0]    r_timer, w_ntimer;
  logic                r_disp, r_ref, r_coin_ret;
  logic                w_buy;

  logic [NUM_ITEMS-1:0][CREDIT_W-1:0] w_prices;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0]  w_stock;
  logic [NUM_ITEMS-1:0]               w_dec;

  logic                w_coin_any, w_accept, w_can_buy;
  logic [SUM_W-1:0]    w_coin_val, w_sum, w_rem;
  logic [CREDIT_W-1:0] w_price, w_sum_sat, w_rem_sat;

  assign w_prices   = price_table;
  assign w_price    = w_prices[r_sel];
  assign w_coin_any = coin_5 | coin_10 | coin_25;
  assign w_accept   = (r_state == S_IDLE) || (r_state == S_COLL);

  assign w_coin_val = (coin_5  ? SUM_W'(5)  : '0)
                    + (coin_10 ? SUM_W'(10) : '0)
                    + (coin_25 ? SUM_W'(25) : '0);
  // Coins coinciding with select/cancel are folded into change, so both
  // the credit and the purchase remainder use the post-coin sum.
  assign w_sum      = SUM_W'(r_total) + w_coin_val;
  assign w_rem      = w_sum - SUM_W'(w_price);
  assign w_sum_sat  = (w_sum > SUM_W'(CMAX)) ? CMAX : w_sum[CREDIT_W-1:0];
  assign w_rem_sat  = (w_rem > SUM_W'(CMAX)) ? CMAX : w_rem[CREDIT_W-1:0];
  // Affordability is judged on the pre-coin credit.
  assign w_can_buy  = (r_total >= w_price) && (w_stock[r_sel] != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_stock
      assign w_dec[gi] = w_buy && (r_sel == SEL_W'(gi));
      vending_stock_ctr #(
        .STOCK_W   (STOCK_W),
        .INIT_STOCK(INIT_STOCK)
      ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .i_restock(restock),
        .i_dec    (w_dec[gi]),
        .o_stock  (w_stock[gi])
      );
    end
  endgenerate

  always_comb begin
    w_nstate  = r_state;
    w_nsel    = r_sel;
    w_ntotal  = r_total;
    w_nchange = r_change;
    w_ntimer  = r_timer;
    w_buy     = 1'b0;
    if (w_accept && next_item)
      w_nsel = (r_sel == SEL_W'(NUM_ITEMS - 1)) ? '0 : r_sel + 1'b1;
    case (r_state)
      S_IDLE: begin
        w_ntotal = w_sum_sat;
        if (w_coin_any) w_nstate = S_COLL;
      end
      S_COLL: begin
        if (cancel) begin
          w_nstate  = S_REF;
          w_nchange = w_sum_sat;
          w_ntotal  = '0;
          w_ntimer  = TMR_W'(DISPENSE_CYCLES);
        end else if (select && w_can_buy) begin
          w_nstate  = S_DISP;
          w_nchange = w_rem_sat;
          w_ntotal  = '0;
          w_ntimer  = TMR_W'(DISPENSE_CYCLES);
          w_buy     = 1'b1;
        end else begin
          w_ntotal = w_sum_sat;
        end
      end
      default: begin
        // Entered with timer=DISPENSE_CYCLES; leaving on 1 gives exactly
        // DISPENSE_CYCLES cycles in the busy state.
        if (r_timer == TMR_W'(1)) begin
          w_nstate  = S_IDLE;
          w_nchange = '0;
          w_ntimer  = '0;
        end else begin
          w_ntimer = r_timer - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_total    <= '0;
      r_change   <= '0;
      r_timer    <= '0;
      r_disp     <= 1'b0;
      r_ref      <= 1'b0;
      r_coin_ret <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_sel      <= w_nsel;
      r_total    <= w_ntotal;
      r_change   <= w_nchange;
      r_timer    <= w_ntimer;
      r_disp     <= (w_nstate == S_DISP);
      r_ref      <= (w_nstate == S_REF);
      r_coin_ret <= w_coin_any && !w_accept;
    end
  end

  assign state         = r_state;
  assign selected_item = r_sel;
  assign total         = r_total;
  assign change        = r_change;
  assign dispense      = r_disp;
  assign refund        = r_ref;
  assign coin_return   = r_coin_ret;
  assign stock_level   = w_stock[r_sel];
  assign sold_out      = (w_stock[r_sel] == '0);
endmodule

// File: tb/tb_vending_core_param.sv
// Randomised scoreboard bench for vending_core_param. A behavioural model
// predicts the outputs after each clock edge; a monitor compares them.
module tb_vending_core_param;
  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int SW   = 4;
  localparam int INIT = 2;
  localparam int DC   = 4;
  localparam int CMAX = 255;

  localparam logic [6:0] C5 = 7'h01, C10 = 7'h02, C25 = 7'h04, NXT = 7'h08,
                         SEL = 7'h10, CAN = 7'h20, RST = 7'h40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coin_5 = 0, coin_10 = 0, coin_25 = 0, next_item = 0;
  logic select = 0, cancel = 0, restock = 0;
  logic [N*CW-1:0] price_table;
  logic [1:0]    selected_item;
  logic [CW-1:0] total, change;
  logic          dispense, refund, coin_return, sold_out;
  logic [SW-1:0] stock_level;
  logic [1:0]    state;

  always #5 clk = ~clk;

  vending_core_param #(
    .NUM_ITEMS(N), .CREDIT_W(CW), .STOCK_W(SW),
    .INIT_STOCK(INIT), .DISPENSE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .coin_5(coin_5), .coin_10(coin_10),
    .coin_25(coin_25), .next_item(next_item), .select(select),
    .cancel(cancel), .restock(restock), .price_table(price_table),
    .selected_item(selected_item), .total(total), .change(change),
    .dispense(dispense), .refund(refund), .coin_return(coin_return),
    .sold_out(sold_out), .stock_level(stock_level), .state(state)
  );

  typedef struct {
    int st, sel, tot, chg, dsp, rfd, cret, sold, lvl;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: 0 idle, 1 collecting, 2 dispensing, 3 refunding.
  int m_st, m_sel, m_tot, m_chg, m_left, m_cret;
  int m_stock[N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int price_of(input int item);
    logic [N*CW-1:0] pt;
    pt = price_table;
    return int'(pt[item*CW +: CW]);
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_sel = 0; m_tot = 0; m_chg = 0; m_left = 0; m_cret = 0;
    foreach (m_stock[i]) m_stock[i] = INIT;
  endtask

  task automatic push_exp();
    exp_t e;
    e.st = m_st; e.sel = m_sel; e.tot = m_tot; e.chg = m_chg;
    e.dsp = (m_st == 2); e.rfd = (m_st == 3); e.cret = m_cret;
    e.sold = (m_stock[m_sel] == 0); e.lvl = m_stock[m_sel];
    q.push_back(e);
  endtask

  task automatic model_step(input logic [6:0] b);
    int coin, p;
    coin = (b[0] ? 5 : 0) + (b[1] ? 10 : 0) + (b[2] ? 25 : 0);
    p = price_of(m_sel);
    m_cret = 0;
    if (m_st <= 1) begin
      if (m_st == 1 && b[5]) begin
        m_chg = sat(m_tot + coin); m_tot = 0; m_st = 3; m_left = DC;
      end else if (m_st == 1 && b[4] && m_tot >= p && m_stock[m_sel] > 0) begin
        m_chg = sat(m_tot + coin - p); m_tot = 0; m_st = 2; m_left = DC;
        m_stock[m_sel]--;
      end else begin
        m_tot = sat(m_tot + coin);
        if (coin > 0) m_st = 1;
      end
      if (b[3]) m_sel = (m_sel + 1) % N;
    end else begin
      m_cret = (coin > 0);
      m_left--;
      if (m_left == 0) begin
        m_st = 0; m_chg = 0;
      end
    end
    if (b[6]) foreach (m_stock[i]) m_stock[i] = INIT;
  endtask

  // One clock cycle: drive inputs, predict, wait for the next negedge.
  task automatic cyc(input logic [6:0] b);
    coin_5 = b[0]; coin_10 = b[1]; coin_25 = b[2]; next_item = b[3];
    select = b[4]; cancel = b[5]; restock = b[6];
    model_step(b);
    push_exp();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(7'h00);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    {coin_5, coin_10, coin_25, next_item, select, cancel, restock} = '0;
    reset = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_sel", selected_item, 0);
    chk("rst_total", total, 0);
    chk("rst_change", change, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_refund", refund, 0);
    chk("rst_coin_return", coin_return, 0);
    chk("rst_stock", stock_level, INIT);
    chk("rst_sold_out", sold_out, 0);
    model_reset();
    push_exp();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", state, e.st);
        chk("selected_item", selected_item, e.sel);
        chk("total", total, e.tot);
        chk("change", change, e.chg);
        chk("dispense", dispense, e.dsp);
        chk("refund", refund, e.rfd);
        chk("coin_return", coin_return, e.cret);
        chk("sold_out", sold_out, e.sold);
        chk("stock_level", stock_level, e.lvl);
      end
    end
  end

  initial begin : stim
    logic [6:0] b;
    price_table = {8'd200, 8'd100, 8'd50, 8'd25};
    #2;
    do_reset();

    // Buy item 0 with exact credit.
    cyc(C25); cyc(SEL); idle(DC + 1);
    // Item 0 now has one left: buy it, then it is sold out.
    cyc(C25); cyc(SEL); idle(DC + 1);
    cyc(C25); cyc(SEL); idle(2);
    // Restock, then the retained credit buys it.
    cyc(RST); cyc(SEL); idle(DC + 1);
    // Overpay item 1: change 25.
    cyc(NXT); cyc(C25); cyc(C25); cyc(C25); cyc(SEL); idle(DC + 1);
    // Selection wraps; insufficient credit keeps COLLECTING.
    cyc(C10); for (int i = 0; i < 4; i++) cyc(NXT); cyc(SEL); idle(1);
    // Cancel refunds the full credit.
    cyc(C25); cyc(C25); cyc(CAN); idle(DC + 1);
    // Saturation, then purchase with coin folded into change.
    for (int i = 0; i < 11; i++) cyc(C25);
    cyc(C5 | C10 | C25); cyc(SEL | C5); idle(1);
    cyc(C5); cyc(C25 | C10); idle(DC);
    // Cancel and select together: cancel wins.
    cyc(C25); cyc(SEL | CAN | C10); idle(DC + 1);
    // Reset in the middle of a dispense.
    cyc(C25 | C10 | C5); cyc(SEL); idle(1); do_reset();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 1) begin
        price_table = {8'($urandom_range(5, 150)), 8'($urandom_range(5, 150)),
                       8'($urandom_range(5, 150)), 8'($urandom_range(5, 150))};
      end
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        b = '0;
        b[0] = ($urandom_range(0, 99) < 15);
        b[1] = ($urandom_range(0, 99) < 15);
        b[2] = ($urandom_range(0, 99) < 20);
        b[3] = ($urandom_range(0, 99) < 10);
        b[4] = ($urandom_range(0, 99) < 20);
        b[5] = ($urandom_range(0, 99) < 4);
        b[6] = ($urandom_range(0, 99) < 2);
        cyc(b);
      end
    end
    idle(2);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
